// File: rtl/e_mdu.sv
// Multiply/divide unit with architectural HI/LO registers.
// Results are computed at launch and committed after a fixed busy period.
module e_mdu #(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        pend_hi_q, pend_hi_d;
  logic [31:0]        pend_lo_q, pend_lo_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;
  logic               done_q, done_d;

  logic [63:0]        prod_s, prod_u;
  logic signed [32:0] dvd_s, dvs_s, quo_s, rem_s;
  logic [31:0]        quo_u, rem_u;
  logic               div_zero;

  // 33-bit signed divide makes 0x80000000 / -1 wrap cleanly to 0x80000000.
  always_comb begin
    prod_s   = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
    prod_u   = {32'd0, rs_val} * {32'd0, rt_val};
    div_zero = (rt_val == 32'd0);
    dvd_s    = $signed({rs_val[31], rs_val});
    dvs_s    = div_zero ? 33'sd1 : $signed({rt_val[31], rt_val});
    quo_s    = dvd_s / dvs_s;
    rem_s    = dvd_s % dvs_s;
    quo_u    = rs_val / (div_zero ? 32'd1 : rt_val);
    rem_u    = rs_val % (div_zero ? 32'd1 : rt_val);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (md_op)
            OP_MULT: begin
              {pend_hi_d, pend_lo_d} = prod_s;
              cnt_d   = CNT_W'(MULT_CYC);
              state_d = ST_RUN;
            end
            OP_MULTU: begin
              {pend_hi_d, pend_lo_d} = prod_u;
              cnt_d   = CNT_W'(MULT_CYC);
              state_d = ST_RUN;
            end
            OP_DIV: begin
              pend_hi_d = div_zero ? hi_q : rem_s[31:0];
              pend_lo_d = div_zero ? lo_q : quo_s[31:0];
              cnt_d     = CNT_W'(DIV_CYC);
              state_d   = ST_RUN;
            end
            OP_DIVU: begin
              pend_hi_d = div_zero ? hi_q : rem_u;
              pend_lo_d = div_zero ? lo_q : quo_u;
              cnt_d     = CNT_W'(DIV_CYC);
              state_d   = ST_RUN;
            end
            OP_MTHI: hi_d = rs_val;
            OP_MTLO: lo_d = rs_val;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        // Last busy cycle: commit at the closing edge, starts are ignored.
        if (cnt_q <= CNT_W'(1)) begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: vector table for arithmetic results and timing,
// plus hand sequences for MTHI/MTLO, ignored starts, back-to-back and reset abort.
module tb_e_mdu;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;

  e_mdu #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .md_op  (md_op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    int          n;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  vec_t vecs[8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Walk through an in-flight operation, checking busy and stable HI/LO each cycle.
  task automatic run_busy(input string nm, input int n, input logic [31:0] hh, input logic [31:0] ll);
    for (int k = 1; k <= n; k++) begin
      chk($sformatf("%s_busy%0d", nm, k), {31'd0, busy}, 32'd1);
      chk($sformatf("%s_done%0d", nm, k), {31'd0, done}, 32'd0);
      chk($sformatf("%s_hold_hi%0d", nm, k), hi, hh);
      chk($sformatf("%s_hold_lo%0d", nm, k), lo, ll);
      rs_val = $urandom;
      rt_val = $urandom;
      step();
    end
  endtask

  initial begin
    vecs[0] = '{3'd1, 32'hFFFFFFFE, 32'd3,        5,  32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[1] = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'h00000001};
    vecs[2] = '{3'd3, 32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000};
    vecs[4] = '{3'd4, 32'd100,      32'd7,        10, 32'd2,        32'd14};
    vecs[5] = '{3'd1, 32'h00010000, 32'h00010000, 5,  32'd1,        32'd0};
    vecs[6] = '{3'd3, 32'd7,        32'hFFFFFFFE, 10, 32'd1,        32'hFFFFFFFD};
    vecs[7] = '{3'd4, 32'hFFFFFFFF, 32'd2,        10, 32'd1,        32'h7FFFFFFF};

    reset = 1'b1; start = 1'b0; md_op = 3'd0; rs_val = '0; rt_val = '0;
    step();
    step();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);

    // First vector launches at the very first edge with reset low.
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      logic [31:0] ph, pl;
      ph = hi; pl = lo;
      start = 1'b1; md_op = vecs[i].op; rs_val = vecs[i].rs; rt_val = vecs[i].rt;
      step();
      start = 1'b0;
      run_busy($sformatf("v%0d", i), vecs[i].n, ph, pl);
      chk($sformatf("v%0d_busy_end", i), {31'd0, busy}, 32'd0);
      chk($sformatf("v%0d_done", i), {31'd0, done}, 32'd1);
      chk($sformatf("v%0d_hi", i), hi, vecs[i].ehi);
      chk($sformatf("v%0d_lo", i), lo, vecs[i].elo);
      step();
      chk($sformatf("v%0d_done_off", i), {31'd0, done}, 32'd0);
    end

    // MTHI/MTLO in idle, then NOPs.
    start = 1'b1; md_op = 3'd5; rs_val = 32'hABCD;
    step();
    start = 1'b0;
    chk("mthi_hi", hi, 32'hABCD);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    chk("mthi_done", {31'd0, done}, 32'd0);
    start = 1'b1; md_op = 3'd6; rs_val = 32'h22;
    step();
    md_op = 3'd5; rs_val = 32'h11;
    step();
    start = 1'b0;
    chk("mt_hi", hi, 32'h11);
    chk("mt_lo", lo, 32'h22);
    start = 1'b1; md_op = 3'd0; rs_val = 32'hFFFF;
    step();
    md_op = 3'd7;
    step();
    start = 1'b0;
    chk("nop_hi", hi, 32'h11);
    chk("nop_lo", lo, 32'h22);
    chk("nop_busy", {31'd0, busy}, 32'd0);

    // DIVU by zero keeps HI/LO.
    start = 1'b1; md_op = 3'd4; rs_val = 32'd7; rt_val = 32'd0;
    step();
    start = 1'b0;
    run_busy("dz", 10, 32'h11, 32'h22);
    chk("dz_done", {31'd0, done}, 32'd1);
    chk("dz_hi", hi, 32'h11);
    chk("dz_lo", lo, 32'h22);

    // MTLO during a multiply is ignored.
    start = 1'b1; md_op = 3'd1; rs_val = 32'd5; rt_val = 32'd6;
    step();
    start = 1'b0;
    step();
    start = 1'b1; md_op = 3'd6; rs_val = 32'h1234;
    step();
    start = 1'b0;
    chk("mtlo_run_lo", lo, 32'h22);
    chk("mtlo_run_busy", {31'd0, busy}, 32'd1);
    step();
    step();
    step();
    chk("mtlo_run_done", {31'd0, done}, 32'd1);
    chk("mtlo_run_lo_end", lo, 32'd30);
    chk("mtlo_run_hi_end", hi, 32'd0);

    // Back-to-back: DIV start held from the MULT launch onward.
    start = 1'b1; md_op = 3'd1; rs_val = 32'd2; rt_val = 32'd3;
    step();
    md_op = 3'd3; rs_val = 32'd100; rt_val = 32'd10;
    for (int k = 1; k <= 5; k++) begin
      chk($sformatf("b2b_busy%0d", k), {31'd0, busy}, 32'd1);
      step();
    end
    chk("b2b_gap_busy", {31'd0, busy}, 32'd0);
    chk("b2b_gap_done", {31'd0, done}, 32'd1);
    chk("b2b_mul_lo", lo, 32'd6);
    step();
    start = 1'b0;
    run_busy("b2b_div", 10, 32'd0, 32'd6);
    chk("b2b_div_busy_end", {31'd0, busy}, 32'd0);
    chk("b2b_div_done", {31'd0, done}, 32'd1);
    chk("b2b_div_lo", lo, 32'd10);
    chk("b2b_div_hi", hi, 32'd0);

    // Reset aborts an in-flight divide.
    start = 1'b1; md_op = 3'd3; rs_val = 32'd100; rt_val = 32'd7;
    step();
    start = 1'b0;
    step();
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    for (int k = 0; k < 15; k++) begin
      step();
      chk($sformatf("abort_after_done%0d", k), {31'd0, done}, 32'd0);
      chk($sformatf("abort_after_lo%0d", k), lo, 32'd0);
      chk($sformatf("abort_after_busy%0d", k), {31'd0, busy}, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
